// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if -- bundle of all handshake and data signals around alu_arbiter.
//
// Signals:
//   req0_* / req1_*  : two requesters (valid/ready, operands a/b, 3-bit op)
//   alu_a/alu_b/alu_op, alu_result : connection to the shared combinational ALU
//   rsp_valid/rsp_ready, rsp_id, rsp_data, rsp_err : single response channel
//
// Modports:
//   slave  : the arbiter side (receives requests, drives ALU and response)
//   master : the environment side (requesters, ALU, response consumer)
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_result, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        output rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_result, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter -- round-robin arbiter sharing one combinational ALU between two
// requesters. One operation is in flight at a time: IDLE accepts, EXEC drives
// the ALU for one cycle and captures its result, RESP holds the response until
// the consumer takes it.
//
// Ports:
//   clk : clock, all logic on the rising edge
//   rst : synchronous active-high reset
//   bus : alu_arbiter_if.slave (requesters, ALU connection, response channel)
//
// Op encodings: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR. Codes 101-111 are
// accepted but answered with rsp_data=0 and rsp_err=1 without using the ALU op.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    localparam logic [2:0] OP_LAST_LEGAL = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    // Requester favoured when both are valid; 0 after reset.
    logic             prio_reg;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       op_reg;
    logic             id_reg;

    logic             rsp_id_reg;
    logic [WIDTH-1:0] rsp_data_reg;
    logic             rsp_err_reg;

    // Requester signals gathered into indexable vectors.
    logic [1:0]       valid_vec;
    logic [1:0]       ready_vec;
    logic [WIDTH-1:0] a_vec  [2];
    logic [WIDTH-1:0] b_vec  [2];
    logic [2:0]       op_vec [2];

    logic             grant_id;
    logic             accept;
    logic             op_legal;

    logic [WIDTH-1:0] alu_a_drv;
    logic [WIDTH-1:0] alu_b_drv;
    logic [2:0]       alu_op_drv;

    assign valid_vec = {bus.req1_valid, bus.req0_valid};
    assign a_vec[0]  = bus.req0_a;
    assign a_vec[1]  = bus.req1_a;
    assign b_vec[0]  = bus.req0_b;
    assign b_vec[1]  = bus.req1_b;
    assign op_vec[0] = bus.req0_op;
    assign op_vec[1] = bus.req1_op;

    // Winner is recomputed every IDLE cycle from the live valids, so a
    // requester that withdraws before a handshake leaves nothing behind.
    assign grant_id = (&valid_vec) ? prio_reg : valid_vec[1];

    // Reset gates the handshake so it wins over any simultaneous request.
    assign accept = (state_reg == IDLE) && !rst && (|valid_vec);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = accept && (grant_id == 1'(gi));
        end
    endgenerate

    assign bus.req0_ready = ready_vec[0];
    assign bus.req1_ready = ready_vec[1];

    assign op_legal = (op_reg <= OP_LAST_LEGAL);

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ALU drive: only during EXEC, with illegal ops presented as 000.
    always_comb begin
        alu_a_drv  = '0;
        alu_b_drv  = '0;
        alu_op_drv = 3'b000;
        if (state_reg == EXEC) begin
            alu_a_drv = a_reg;
            alu_b_drv = b_reg;
            if (op_legal) begin
                alu_op_drv = op_reg;
            end
        end
    end

    assign bus.alu_a     = alu_a_drv;
    assign bus.alu_b     = alu_b_drv;
    assign bus.alu_op    = alu_op_drv;

    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_err   = rsp_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_reg     <= 1'b0;
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= 3'b000;
            id_reg       <= 1'b0;
            rsp_id_reg   <= 1'b0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            if (accept) begin
                a_reg  <= a_vec[grant_id];
                b_reg  <= b_vec[grant_id];
                op_reg <= op_vec[grant_id];
                id_reg <= grant_id;
            end
            if (state_reg == EXEC) begin
                rsp_id_reg   <= id_reg;
                rsp_err_reg  <= !op_legal;
                rsp_data_reg <= op_legal ? bus.alu_result : '0;
            end
            // Completed response hands priority to the other requester.
            if ((state_reg == RESP) && bus.rsp_ready) begin
                prio_reg <= ~rsp_id_reg;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(W)) bus ();

    alu_arbiter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int favour = 0;   // model: requester preferred under contention

    // Plain arithmetic meaning of each op code; illegal codes give 0.
    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return '0;
        endcase
    endfunction

    // The environment's shared ALU.
    assign bus.alu_result = ref_alu(bus.alu_a, bus.alu_b, bus.alu_op);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ready0"},    64'(bus.req0_ready), 64'(0));
        check({tag, " ready1"},    64'(bus.req1_ready), 64'(0));
        check({tag, " alu_a"},     64'(bus.alu_a),      64'(0));
        check({tag, " alu_b"},     64'(bus.alu_b),      64'(0));
        check({tag, " alu_op"},    64'(bus.alu_op),     64'(0));
        check({tag, " rsp_valid"}, 64'(bus.rsp_valid),  64'(0));
        check({tag, " rsp_id"},    64'(bus.rsp_id),     64'(0));
        check({tag, " rsp_data"},  64'(bus.rsp_data),   64'(0));
        check({tag, " rsp_err"},   64'(bus.rsp_err),    64'(0));
    endtask

    // One complete transaction from IDLE. who: 0/1 single requester, 2 both.
    task automatic run_op(input int who,
                          input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [2:0] op0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [2:0] op1,
                          input int stall);
        int win;
        logic [W-1:0] ea, eb, ed;
        logic [2:0]   eop;
        logic         eerr;
        win  = (who == 2) ? favour : who;
        ea   = (win == 1) ? a1 : a0;
        eb   = (win == 1) ? b1 : b0;
        eop  = (win == 1) ? op1 : op0;
        eerr = (eop > 3'd4);
        ed   = ref_alu(ea, eb, eop);

        // Accept cycle; rsp_ready high here and in EXEC must be ignored.
        bus.req0_valid = (who != 1);
        bus.req1_valid = (who != 0);
        bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
        bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
        bus.rsp_ready = 1'b1;
        #1;
        check("idle ready0", 64'(bus.req0_ready), 64'(win == 0));
        check("idle ready1", 64'(bus.req1_ready), 64'(win == 1));
        check("idle alu_op", 64'(bus.alu_op), 64'(0));
        check("idle rsp_valid", 64'(bus.rsp_valid), 64'(0));

        cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        check("exec ready0", 64'(bus.req0_ready), 64'(0));
        check("exec ready1", 64'(bus.req1_ready), 64'(0));
        check("exec alu_a", 64'(bus.alu_a), 64'(ea));
        check("exec alu_b", 64'(bus.alu_b), 64'(eb));
        check("exec alu_op", 64'(bus.alu_op), 64'(eerr ? 3'd0 : eop));
        check("exec rsp_valid", 64'(bus.rsp_valid), 64'(0));

        cyc();
        bus.rsp_ready = (stall == 0);
        check("resp rsp_valid", 64'(bus.rsp_valid), 64'(1));
        check("resp rsp_id", 64'(bus.rsp_id), 64'(win));
        check("resp rsp_data", 64'(bus.rsp_data), 64'(ed));
        check("resp rsp_err", 64'(bus.rsp_err), 64'(eerr));
        check("resp alu_a", 64'(bus.alu_a), 64'(0));

        // Backpressure: requests presented now must not be accepted.
        for (int s = 0; s < stall; s++) begin
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            #1;
            check("stall ready0", 64'(bus.req0_ready), 64'(0));
            check("stall ready1", 64'(bus.req1_ready), 64'(0));
            cyc();
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            bus.rsp_ready  = (s == stall - 1);
            check("stall rsp_valid", 64'(bus.rsp_valid), 64'(1));
            check("stall rsp_data", 64'(bus.rsp_data), 64'(ed));
            check("stall rsp_id", 64'(bus.rsp_id), 64'(win));
        end

        cyc();
        bus.rsp_ready = 1'b0;
        check("done rsp_valid", 64'(bus.rsp_valid), 64'(0));
        favour = 1 - win;
        $display("txn who=%0d win=%0d a=%0h b=%0h op=%0d data=%0h err=%0d stall=%0d",
                 who, win, ea, eb, eop, ed, eerr, stall);
    endtask

    initial begin
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = '1; bus.req0_b = '1; bus.req0_op = 3'd0;
        bus.req1_valid = 1'b1; bus.req1_a = '1; bus.req1_b = '1; bus.req1_op = 3'd0;
        bus.rsp_ready  = 1'b0;

        // Reset with both requesters valid: nothing may be granted.
        cyc();
        cyc();
        check_all_zero("reset");
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        favour = 0;
        cyc();

        // Single op and op sweep on requester 0.
        run_op(0, 32'd15, 32'd10, 3'd0, '0, '0, 3'd0, 0);
        check("add literal", 64'(ref_alu(32'd15, 32'd10, 3'd0)), 64'd25);
        for (int k = 1; k <= 4; k++) begin
            run_op(0, 32'd15, 32'd10, 3'(k), '0, '0, 3'd0, 0);
        end

        // Wrap-around subtract and illegal op on requester 1.
        run_op(1, '0, '0, 3'd0, 32'd0, 32'd1, 3'd1, 1);
        run_op(1, '0, '0, 3'd0, 32'd0, 32'd1, 3'd6, 0);

        // Backpressure for five cycles under contention.
        run_op(2, 32'h1234, 32'h0F0F, 3'd2, 32'h5555, 32'hAAAA, 3'd3, 5);

        // Make requester 1 favoured, then reset during EXEC.
        run_op(0, 32'd7, 32'd3, 3'd0, '0, '0, 3'd0, 0);
        bus.req0_valid = 1'b1; bus.req0_a = 32'd9; bus.req0_b = 32'd4; bus.req0_op = 3'd0;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd8; bus.req1_b = 32'd2; bus.req1_op = 3'd1;
        cyc();
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        cyc();
        check_all_zero("midop reset");
        rst = 1'b0;
        favour = 0;
        for (int k = 0; k < 2; k++) begin
            cyc();
            check("no orphan rsp_valid", 64'(bus.rsp_valid), 64'(0));
        end
        $display("txn reset during EXEC, in-flight op dropped");

        // Contention from reset: accepts every 3 cycles, alternating 0,1,0,1.
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.rsp_ready  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            int w;
            w = (k / 3) % 2;
            #1;
            check("cont ready0", 64'(bus.req0_ready), 64'((k % 3 == 0) && (w == 0)));
            check("cont ready1", 64'(bus.req1_ready), 64'((k % 3 == 0) && (w == 1)));
            if (k % 3 == 2) begin
                check("cont rsp_id", 64'(bus.rsp_id), 64'(w));
                $display("txn contention grant=%0d at cycle %0d", w, k - 2);
            end
            cyc();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        favour = 0;
        cyc();

        // Randomized transactions against the model.
        for (int n = 0; n < 30; n++) begin
            run_op(int'($urandom_range(0, 2)),
                   W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
                   W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
                   int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
